// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM state encoding,
// algorithm selectors and the width rule for the Stein power-of-two exponent.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_EUCLID = 0;
    localparam int MODE_STEIN  = 1;

    // k counts common factors of two, which can never exceed WIDTH
    function automatic int k_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_if.sv
// Operand/result channel of the GCD engine: valid/ready in, valid/ready out
// plus the iteration count that travels with the result.
interface gcd_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 16
);
    logic                 in_valid;
    logic [2*WIDTH-1:0]   in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [STEP_W-1:0]    out_steps;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_steps
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_steps
    );
endinterface

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtractive Euclid or binary Stein,
// flagging the terminal case (either operand zero) and its shifted result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_EUCLID,
    localparam int KW   = k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic [KW-1:0]    k_next,
    output logic             terminal,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        a_next   = a;
        b_next   = b;
        k_next   = k;
        terminal = 1'b0;
        result   = (a | b) << k;
        if (a == '0 || b == '0) begin
            terminal = 1'b1;
        end else if (MODE == MODE_STEIN) begin
            // compare guards both subtractions against underflow
            if (!a[0] && !b[0]) begin
                a_next = a >> 1;
                b_next = b >> 1;
                k_next = k + KW'(1);
            end else if (!a[0]) begin
                a_next = a >> 1;
            end else if (!b[0]) begin
                b_next = b >> 1;
            end else if (a >= b) begin
                a_next = (a - b) >> 1;
            end else begin
                b_next = (b - a) >> 1;
            end
        end else begin
            if (a >= b) a_next = a - b;
            else        b_next = b - a;
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD engine: captures an operand pair, runs one gcd_step per
// clock, then holds the result and saturating step count until accepted.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MODE   = MODE_EUCLID,
    parameter int STEP_W = 16
) (
    input  logic clk,
    input  logic reset,
    gcd_if.slave io
);

    localparam int KW = k_width(WIDTH);

    state_t            state, state_next;
    logic [WIDTH-1:0]  a, b, result;
    logic [KW-1:0]     k;
    logic [STEP_W-1:0] steps;

    logic [WIDTH-1:0]  a_step, b_step, res_step;
    logic [KW-1:0]     k_step;
    logic              terminal;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (&v) ? v : v + STEP_W'(1);
    endfunction

    gcd_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_step (
        .a        (a),
        .b        (b),
        .k        (k),
        .a_next   (a_step),
        .b_next   (b_step),
        .k_next   (k_step),
        .terminal (terminal),
        .result   (res_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io.in_valid)  state_next = CALC;
            CALC:    if (terminal)     state_next = DONE;
            DONE:    if (io.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a      <= '0;
            b      <= '0;
            k      <= '0;
            steps  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        a     <= io.in_data[2*WIDTH-1:WIDTH];
                        b     <= io.in_data[WIDTH-1:0];
                        k     <= '0;
                        steps <= '0;
                    end
                end
                CALC: begin
                    steps <= sat_inc(steps);
                    a     <= a_step;
                    b     <= b_step;
                    k     <= k_step;
                    if (terminal) result <= res_step;
                end
                default: ;
            endcase
        end
    end

    // handshake outputs come from state only, so out_ready never reaches in_ready
    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.out_data  = result;
    assign io.out_steps = steps;

endmodule
